// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked RV32 data memory with lane select, configurable load latency and fault detection
module data_mem_hs #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic [31:0] off, word_rd, ld_val, wmask, wdata_sh, wmerge;
  logic [29:0] word;
  logic [1:0] lane;
  logic [AW-1:0] widx;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic acc, mis, oor, ill, fault;
  assign off      = req_addr - BASE_ADDR;
  assign word     = off[31:2];
  assign lane     = off[1:0];
  assign widx     = word[AW-1:0];
  assign req_ready = state_q == IDLE;
  assign acc      = req_valid & req_ready;
  assign mis      = (req_func3[1:0] == 2'b01 && lane[0]) || (req_func3[1:0] == 2'b10 && lane != 2'b00);
  assign oor      = req_addr < BASE_ADDR || {2'b00, word} >= 32'(DEPTH);
  assign ill      = req_we ? req_func3 > 3'd2 : (req_func3 == 3'b011 || req_func3[2:1] == 2'b11);
  assign fault    = mis | oor | ill;
  assign word_rd  = mem[widx];
  assign bsel     = word_rd[{lane, 3'b000} +: 8];
  assign hsel     = lane[1] ? word_rd[31:16] : word_rd[15:0];
  assign ld_val   = req_func3 == 3'b000 ? {{24{bsel[7]}}, bsel} :
                    req_func3 == 3'b001 ? {{16{hsel[15]}}, hsel} :
                    req_func3 == 3'b100 ? {24'h0, bsel} :
                    req_func3 == 3'b101 ? {16'h0, hsel} : word_rd;
  assign wmask    = req_func3 == 3'b000 ? 32'hFF << {lane, 3'b000} :
                    req_func3 == 3'b001 ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
  assign wdata_sh = req_func3 == 3'b000 ? {4{req_wdata[7:0]}} :
                    req_func3 == 3'b001 ? {2{req_wdata[15:0]}} : req_wdata;
  assign wmerge   = (word_rd & ~wmask) | (wdata_sh & wmask);
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = state_q != IDLE;
  // store commits on the acceptance edge unless faulted; array is never cleared
  always_ff @(posedge clk)
    if (!rst && acc && req_we && !fault) mem[widx] <= wmerge;
  // handshake sequencing; response data is captured at acceptance and cleared on leaving RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (acc) begin
        err_d   = fault;
        rdata_d = (fault || req_we) ? 32'h0 : ld_val;
        cnt_d   = 2'd0;
        state_d = (fault || req_we || RD_LAT == 1) ? RESP : LOAD_WAIT;
      end
      LOAD_WAIT: if (cnt_q == 2'(RD_LAT - 2)) state_d = RESP;
                 else cnt_d = cnt_q + 2'd1;
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset overriding everything
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs: directed scoreboard bench over three data_mem_hs configurations
module tb_data_mem_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst, rvld, rrdy;
  logic we;
  logic [31:0] addr, wdata;
  logic [2:0] f3;
  logic rdy [3], rv [3], er [3], bz [3];
  logic [31:0] rd [3];
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb [$];

  data_mem_hs #(.DEPTH(16), .RD_LAT(1)) u1 (.clk(clk), .rst(rst[0]), .req_valid(rvld[0]), .req_ready(rdy[0]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_func3(f3), .rsp_valid(rv[0]), .rsp_ready(rrdy[0]),
    .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bz[0]));
  data_mem_hs #(.DEPTH(256), .RD_LAT(3)) u3 (.clk(clk), .rst(rst[1]), .req_valid(rvld[1]), .req_ready(rdy[1]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_func3(f3), .rsp_valid(rv[1]), .rsp_ready(rrdy[1]),
    .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bz[1]));
  data_mem_hs #(.DEPTH(256), .RD_LAT(4)) u4 (.clk(clk), .rst(rst[2]), .req_valid(rvld[2]), .req_ready(rdy[2]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_func3(f3), .rsp_valid(rv[2]), .rsp_ready(rrdy[2]),
    .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bz[2]));

  function automatic int lat_of(input int s);
    return s == 0 ? 1 : s == 1 ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input int s, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int n = 0;
    @(negedge clk);
    we = w; addr = a; wdata = d; f3 = f; rvld[s] = 1'b1;
    while (!rdy[s] && n < 20) begin @(negedge clk); n++; end
    if (!rdy[s]) chk("accept timeout", 32'(rdy[s]), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int s, input string tag);
    int lat = 1;
    exp_t e;
    while (!rv[s] && lat < 20) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    chk({tag, " valid"}, 32'(rv[s]), 32'd1);
    chk({tag, " rdata"}, rd[s], e.rdata);
    chk({tag, " err"}, 32'(er[s]), 32'(e.err));
    chk({tag, " lat"}, 32'(lat), 32'(e.lat));
    rrdy[s] = 1'b1;
    @(posedge clk); #1;
    rrdy[s] = 1'b0;
    chk({tag, " rv drop"}, 32'(rv[s]), 32'd0);
    chk({tag, " ready"}, 32'(rdy[s]), 32'd1);
  endtask

  task automatic xact(input int s, input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic [31:0] xr, input logic xe);
    exp_t e;
    e.rdata = xr; e.err = xe; e.lat = (xe || w) ? 1 : lat_of(s);
    sb.push_back(e);
    present(s, w, a, d, f);
    rvld[s] = 1'b0;
    wait_rsp(s, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int lat;
    rst = 3'b111; rvld = 3'b000; rrdy = 3'b000; we = 1'b0; addr = 32'h0; wdata = 32'h0; f3 = 3'b010;
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    chk("rst rv", 32'(rv[0]), 32'd0);
    chk("rst rdata", rd[0], 32'h0);
    chk("rst err", 32'(er[0]), 32'd0);
    chk("rst ready", 32'(rdy[0]), 32'd1);
    chk("rst busy", 32'(bz[0]), 32'd0);
    xact(0, "sw10", 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    xact(0, "lw10", 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    xact(0, "sw20", 1, 32'h20, 32'h11223344, 3'b010, 32'h0, 0);
    xact(0, "sb23", 1, 32'h23, 32'h123456A5, 3'b000, 32'h0, 0);
    xact(0, "lb23", 0, 32'h23, 32'h0, 3'b000, 32'hFFFFFFA5, 0);
    xact(0, "lbu23", 0, 32'h23, 32'h0, 3'b100, 32'h000000A5, 0);
    xact(0, "lw20", 0, 32'h20, 32'h0, 3'b010, 32'hA5223344, 0);
    xact(0, "sw30", 1, 32'h30, 32'hCAFE9876, 3'b010, 32'h0, 0);
    xact(0, "sh32", 1, 32'h32, 32'h55558001, 3'b001, 32'h0, 0);
    xact(0, "lh32", 0, 32'h32, 32'h0, 3'b001, 32'hFFFF8001, 0);
    xact(0, "lhu30", 0, 32'h30, 32'h0, 3'b101, 32'h00009876, 0);
    xact(0, "lh31 mis", 0, 32'h31, 32'h0, 3'b001, 32'h0, 1);
    xact(0, "sh31 mis", 1, 32'h31, 32'hFFFFFFFF, 3'b001, 32'h0, 1);
    xact(0, "lw30", 0, 32'h30, 32'h0, 3'b010, 32'h80019876, 0);
    xact(0, "lw12 mis", 0, 32'h12, 32'h0, 3'b010, 32'h0, 1);
    xact(0, "sw3c", 1, 32'h3C, 32'h0F0F0F0F, 3'b010, 32'h0, 0);
    xact(0, "lw3c", 0, 32'h3C, 32'h0, 3'b010, 32'h0F0F0F0F, 0);
    xact(0, "sw00", 1, 32'h00, 32'h01010101, 3'b010, 32'h0, 0);
    xact(0, "sw40 oor", 1, 32'h40, 32'hFFFFFFFF, 3'b010, 32'h0, 1);
    xact(0, "lw40 oor", 0, 32'h40, 32'h0, 3'b010, 32'h0, 1);
    xact(0, "lw00", 0, 32'h00, 32'h0, 3'b010, 32'h01010101, 0);
    xact(0, "ld f3 011", 0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
    xact(0, "ld f3 110", 0, 32'h10, 32'h0, 3'b110, 32'h0, 1);
    xact(0, "st f3 100", 1, 32'h10, 32'h0, 3'b100, 32'h0, 1);
    xact(0, "lw10 again", 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
    xact(1, "u3 sw08", 1, 32'h08, 32'h0BADF00D, 3'b010, 32'h0, 0);
    e.rdata = 32'h0BADF00D; e.err = 1'b0; e.lat = 3;
    sb.push_back(e);
    sb.push_back(e);
    present(1, 0, 32'h08, 32'h0, 3'b010);
    lat = 1;
    while (!rv[1] && lat < 20) begin
      chk("u3 wait ready", 32'(rdy[1]), 32'd0);
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    chk("u3 hold valid", 32'(rv[1]), 32'd1);
    chk("u3 hold lat", 32'(lat), 32'(e.lat));
    repeat (5) begin
      @(posedge clk); #1;
      chk("u3 hold rv", 32'(rv[1]), 32'd1);
      chk("u3 hold rdata", rd[1], e.rdata);
      chk("u3 hold ready", 32'(rdy[1]), 32'd0);
    end
    rrdy[1] = 1'b1;
    @(posedge clk); #1;
    rrdy[1] = 1'b0;
    chk("u3 hs rv", 32'(rv[1]), 32'd0);
    chk("u3 hs ready", 32'(rdy[1]), 32'd1);
    @(posedge clk); #1;
    rvld[1] = 1'b0;
    chk("u3 next busy", 32'(bz[1]), 32'd1);
    wait_rsp(1, "u3 next");
    xact(2, "u4 sw04", 1, 32'h04, 32'h13579BDF, 3'b010, 32'h0, 0);
    present(2, 0, 32'h04, 32'h0, 3'b010);
    rvld[2] = 1'b0;
    chk("u4 busy", 32'(bz[2]), 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    repeat (6) begin
      chk("u4 post rst rv", 32'(rv[2]), 32'd0);
      @(posedge clk); #1;
    end
    chk("u4 post rst ready", 32'(rdy[2]), 32'd1);
    chk("u4 post rst busy", 32'(bz[2]), 32'd0);
    xact(2, "u4 lw04", 0, 32'h04, 32'h0, 3'b010, 32'h13579BDF, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Parametrised next-generation data memory for the RV32 core's load/store path, driven by the ALU-computed address and funct3.
- Adds:
  - a valid/ready request/response handshake;
  - configurable read latency;
  - correct byte/halfword lane selection on loads;
  - misaligned, out-of-range and illegal-funct3 fault detection.
- One request in flight at a time; sits between the LSU and the word-organised data array.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two not required, >=1).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned).
- RD_LAT, 1, load latency in cycles from acceptance to rsp_valid (legal 1..4).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- req_func3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request faulted; qualifies rsp_valid
- busy  out  1  ~IDLE

Behaviour:
- **Reset:** state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory array is not cleared. Reset overrides all other events in the same cycle.
- **States:**
  - IDLE (req_ready=1)
  - LOAD_WAIT (count RD_LAT-1 cycles)
  - RESP (rsp_valid=1)
- **Acceptance:** on an edge with req_valid & req_ready. req_ready is 0 outside IDLE; requests presented then are ignored and must be held by the LSU.
- **Address decode:** off = req_addr - BASE_ADDR, word = off[31:2], lane = req_addr[1:0].
- **Faults,** checked at acceptance; any fault suppresses the memory write:
  - misaligned: H/HU with lane[0]=1; W with lane!=0.
  - out-of-range: req_addr < BASE_ADDR, or word >= DEPTH.
  - illegal funct3:
    - loads: 011, 110, 111;
    - stores: anything other than 000/001/010.
- **Fault path:** IDLE -> RESP next cycle, rsp_err=1, rsp_rdata=0. Latency is 1 regardless of RD_LAT.
- **Store path:** write commits on the acceptance edge, lane-merged with the old word:
  - SB: byte lane = wdata[7:0];
  - SH: half lane[1] = wdata[15:0];
  - SW: full word.
  - Then IDLE -> RESP, rsp_err=0, rsp_rdata=0.
- **Load path:**
  - Word read at the acceptance edge, registered along with funct3 and lane.
  - RD_LAT=1: IDLE -> RESP.
  - Otherwise: IDLE -> LOAD_WAIT, counter counts to RD_LAT-1, then -> RESP.
  - rsp_valid first high exactly RD_LAT cycles after acceptance.
- **Load extraction:**
  - LB/LBU select byte[lane]; LH/LHU select half[lane[1]].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW is unmodified.
- **RESP:**
  - rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that edge: -> IDLE, rsp_valid=0. The next request can be accepted the following cycle.
  - No same-cycle response-and-accept.
- **Read-after-write:** a load accepted after a store's response returns the stored data; there is never concurrency between them.
- **Reset mid-operation:**
  - a committed store remains in memory;
  - a pending load or response is discarded;
  - no rsp_valid after reset until a new request is accepted.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 with RD_LAT=1 -> store rsp 1 cycle after accept, err=0; load rsp_rdata=0xDEADBEEF exactly 1 cycle after accept.
- Word 0x20 preset 0x11223344; SB 0x23 wdata=0xA5, then LB 0x23 -> 0xFFFFFFA5; LBU 0x23 -> 0x000000A5; LW 0x20 -> 0xA5223344.
- SH 0x32 wdata=0x8001, then LH 0x32 -> 0xFFFF8001; LHU 0x30 -> old low half zero-extended; LH 0x31 -> err=1, rdata=0, memory unchanged.
- DEPTH=16: SW 0x40 -> err=1 with no write; LW 0x3C -> err=0; funct3=011 load -> err=1; store funct3=100 -> err=1.
- RD_LAT=3, LW with rsp_ready low 5 cycles -> rsp_valid rises 3 cycles after accept and holds stable. req_ready=0 throughout while req_valid is held; the next request is accepted the cycle after the rsp handshake.
- Assert rst while in LOAD_WAIT (RD_LAT=4) -> rsp_valid stays 0 and state returns to IDLE. A prior SW value is still readable after reset.
